// File: rtl/prescaler0.sv
// prescaler0 -- synchronous prescaler for Timer/Counter 0/1/3/4 plus the GTCCR
// control register (TSM, PSRASY, PSRSYNC).
//
// A 10-bit free-running counter produces single-cycle clock-enable pulses
// every 8, 64, 256 and 1024 clk cycles. PSRSYNC holds the counter at zero.
// Without TSM, PSRSYNC self-clears after one held cycle. With TSM set, it
// stays set until software clears TSM. PSRASY is only a flag handed to the
// Timer2 asynchronous prescaler. That prescaler reports completion on
// psr2_done.
//
// Ports
//   clk          in   clock; all state changes on the rising edge
//   rst_n        in   synchronous active-low reset
//   gtccr_we     in   single-cycle GTCCR write strobe
//   gtccr_wdata  in   [7] TSM, [1] PSRASY, [0] PSRSYNC; [6:2] ignored
//   psr2_done    in   Timer2 prescaler reset complete (clears PSRASY)
//   gtccr_rdata  out  {TSM, 5'b0, PSRASY, PSRSYNC}
//   clk8en       out  enable pulse, period 8
//   clk64en      out  enable pulse, period 64
//   clk256en     out  enable pulse, period 256
//   clk1024en    out  enable pulse, period 1024
//   psrasy_o     out  current PSRASY level
module prescaler0 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gtccr_we,
    input  logic [7:0] gtccr_wdata,
    input  logic       psr2_done,
    output logic [7:0] gtccr_rdata,
    output logic       clk8en,
    output logic       clk64en,
    output logic       clk256en,
    output logic       clk1024en,
    output logic       psrasy_o
);

    logic [9:0] cnt;
    logic       tsm;
    logic       psrsync;
    logic       psrasy;
    logic       run;

    // Bits 6:2 of the write data have no storage.
    logic unused_wdata;
    assign unused_wdata = ^gtccr_wdata[6:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            tsm     <= 1'b0;
            psrsync <= 1'b0;
            psrasy  <= 1'b0;
        end else begin
            // The counter is held at zero for every cycle in which PSRSYNC
            // reads 1. The first counting cycle therefore always shows 0.
            if (psrsync) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 10'd1;
            end

            if (gtccr_we) begin
                tsm <= gtccr_wdata[7];
            end

            // A software set outranks the hardware clear in the same cycle.
            // The clear depends on the TSM value before this edge. Writing
            // TSM=0 while held therefore still gives one more held cycle.
            if (gtccr_we && gtccr_wdata[0]) begin
                psrsync <= 1'b1;
            end else if (!tsm) begin
                psrsync <= 1'b0;
            end

            if (gtccr_we && gtccr_wdata[1]) begin
                psrasy <= 1'b1;
            end else if (psr2_done && !tsm) begin
                psrasy <= 1'b0;
            end
        end
    end

    // Outputs read as zero during the reset cycle itself, before the
    // clearing edge has been seen.
    always_comb begin
        run         = rst_n & ~psrsync;
        clk8en      = run & (cnt[2:0] == 3'd7);
        clk64en     = run & (cnt[5:0] == 6'd63);
        clk256en    = run & (cnt[7:0] == 8'd255);
        clk1024en   = run & (cnt == 10'd1023);
        psrasy_o    = rst_n & psrasy;
        gtccr_rdata = rst_n ? {tsm, 5'b00000, psrasy, psrsync} : 8'h00;
    end

endmodule

// File: doc/prescaler0.md
PRESCALER0 -- requirements
Module: prescaler0

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Port: clk  input  1  I/O clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Port: gtccr_we  input  1  single-cycle write strobe for the GTCCR register.
REQ-005 Port: gtccr_wdata  input  8  write data; bit7 TSM, bit1 PSRASY, bit0 PSRSYNC; bits 6:2 ignored.
REQ-006 Port: psr2_done  input  1  Timer2 asynchronous prescaler reset complete; clears PSRASY.
REQ-007 Port: gtccr_rdata  output  8  {TSM, 5'b0, PSRASY, PSRSYNC}, combinational from register state.
REQ-008 Port: clk8en, clk64en, clk256en, clk1024en  output  1 each  single-cycle clock-enable pulses to the downstream clock-select mux for Timer/Counter 0/1/3/4.
REQ-009 Port: psrasy_o  output  1  level equal to the PSRASY bit, routed to the Timer2 prescaler.

Function
REQ-010 The block SHALL hold a 10-bit free-running counter cnt that increments by 1 each clk while PSRSYNC=0.
- Wrap: 1023 -> 0, with no gap cycle.
REQ-011 The enable outputs SHALL be combinational decodes of cnt, gated by ~PSRSYNC:
- clk8en = (cnt[2:0]==7)
- clk64en = (cnt[5:0]==63)
- clk256en = (cnt[7:0]==255)
- clk1024en = (cnt==1023)
REQ-012 Each enable SHALL be high for exactly one cycle per period, with periods 8, 64, 256 and 1024 clk; zero latency from cnt.
REQ-013 When cnt==1023, all four enables SHALL be high in the same cycle.
REQ-014 When gtccr_we=1, writing a 1 to bit0 SHALL set PSRSYNC; writing a 0 to bit0 SHALL leave PSRSYNC unchanged.
REQ-015 When gtccr_we=1, writing a 1 to bit1 SHALL set PSRASY; writing a 0 to bit1 SHALL leave PSRASY unchanged.
REQ-016 When gtccr_we=1, bit7 SHALL load TSM directly (write 1 sets it, write 0 clears it).
REQ-017 While PSRSYNC=1, cnt SHALL be loaded with 0 on every edge and all four enables SHALL be 0.
REQ-018 With TSM=0, PSRSYNC SHALL be cleared by hardware on the edge after the cycle in which it reads 1.
- A PSRSYNC write therefore holds the prescaler for exactly one cycle.
- Counting resumes from 0 the following cycle.
REQ-019 With TSM=1, PSRSYNC SHALL NOT be cleared by hardware; the prescaler SHALL remain held until TSM is written 0.
REQ-020 When TSM is written 0 while PSRSYNC=1, PSRSYNC SHALL clear one cycle later (the TSM=0 hold rule applies); cnt=0 in the first counting cycle.
REQ-021 Write priority: a write setting PSRSYNC/PSRASY in the same cycle as a hardware clear SHALL win; the bit reads 1 next cycle.
REQ-022 PSRASY SHALL be cleared on the edge where psr2_done=1 and TSM=0, subject to REQ-021; with TSM=1 it SHALL remain set.
REQ-023 gtccr_rdata SHALL reflect register state updated by the most recent edge, with no read side effects.

Reset
REQ-024 On the edge where rst_n=0, the block SHALL set cnt=0, TSM=0, PSRSYNC=0 and PSRASY=0; gtccr_we is ignored in that cycle.
REQ-025 While in reset, gtccr_rdata, psrasy_o and all four enables SHALL read 0.
REQ-026 After reset deassertion, counting SHALL start with cnt=0 in the first cycle; the first clk8en occurs in cycle 8 (cnt=7).
REQ-027 Reset applied mid-count or mid-hold SHALL take effect on that edge with identical results.

Verification
REQ-028 Reset release then 2048 free-running cycles -> clk8en/64en/256en/1024en pulse counts of 256/32/8/2; first pulses in cycles 8/64/256/1024; all four high together at cnt=1023.
REQ-029 At cnt=100, write 0x01 -> gtccr_rdata=0x01 for one cycle with all enables 0; next cycle cnt=0; next clk8en 8 cycles later; PSRSYNC reads 0 thereafter.
REQ-030 Write 0x81, wait 50 cycles -> gtccr_rdata stays 0x81 with no enable pulses; write 0x00 -> PSRSYNC clears one cycle later; clk8en reappears 8 cycles after counting resumes.
REQ-031 Write 0x02, then pulse psr2_done -> psrasy_o=1 until the edge sampling psr2_done, then 0; repeat with TSM=1 -> psrasy_o stays 1.
REQ-032 Assert rst_n=0 for one cycle at cnt=511 while TSM=1 and PSRSYNC=1 -> gtccr_rdata=0x00 and cnt=0; normal counting resumes after release.
REQ-033 Write 0x01 in the same cycle PSRSYNC would auto-clear -> PSRSYNC stays 1 for one more cycle, per REQ-021.
